muldiv_seq: RTL

- Multi-cycle sequencer for RV32M integer multiply/divide, reusing the shared 32-bit ALU instead of a dedicated multiplier or divider array.
- Accepts one operation over a valid/ready request channel and drives the ALU operands and select every cycle.
- Returns the result over a valid/ready response channel.
- Sits beside the execute stage; the core stalls on busy.

---
 rtl/muldiv_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide controller that borrows the shared 32-bit ALU.
// Shift-add multiply (32 steps), restoring divide (32 compare/subtract pairs), sign fix-up at the end.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a request, req_ready high
// PREP_A   | negate a through the ALU when signed and negative
// PREP_B   | negate b through the ALU when signed and negative
// MUL_STEP | one shift-add multiply step
// DIV_CMP  | shift remainder in, compare against divisor (SLTU)
// DIV_SUB  | conditional subtract, shift quotient bit in
// FIX      | restore the result sign, register the response
// DONE     | response valid until resp_ready
module muldiv_seq #(
    parameter int W_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [W_SIZE-1:0] req_a,
    input  logic [W_SIZE-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [W_SIZE-1:0] resp_data,
    output logic              resp_err,
    output logic              busy,
    output logic [W_SIZE-1:0] alu_a,
    output logic [W_SIZE-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [W_SIZE-1:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP_A, S_PREP_B, S_MUL_STEP, S_DIV_CMP, S_DIV_SUB, S_FIX, S_DONE
    } state_t;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b1000;
    localparam logic [3:0] SEL_SLTU = 4'b0011;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [W_SIZE-1:0]   a_q, a_d;      // multiplicand, or dividend shifting out
    logic [W_SIZE-1:0]   b_q, b_d;      // multiplier, or divisor
    logic [W_SIZE-1:0]   acc_q, acc_d;  // product accumulator, or remainder
    logic [W_SIZE-1:0]   quo_q, quo_d;
    logic [W_SIZE-1:0]   res_q, res_d;
    logic                err_q, err_d;
    logic                a_neg_q, a_neg_d;
    logic                b_neg_q, b_neg_d;
    logic                ge_q, ge_d;
    logic [4:0]          cnt_q, cnt_d;

    logic accept, req_unsup, req_div, req_signed, req_div0, req_ovf, req_fast;
    logic op_signed;

    assign accept     = req_valid && !kill && (state_q == S_IDLE);
    assign req_unsup  = (req_op != 3'b000) && !req_op[2];
    assign req_div    = req_op[2];
    assign req_signed = req_op[2] && !req_op[0];
    assign req_div0   = req_div && (req_b == '0);
    assign req_ovf    = req_signed && (req_a == {1'b1, {(W_SIZE-1){1'b0}}}) && (req_b == '1);
    assign req_fast   = req_unsup || req_div0 || req_ovf;
    assign op_signed  = op_q[2] && !op_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            ge_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            err_q   <= err_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            ge_q    <= ge_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = req_fast ? S_DONE : S_PREP_A;
            S_PREP_A:   state_d = S_PREP_B;
            S_PREP_B:   state_d = (op_q == 3'b000) ? S_MUL_STEP : S_DIV_CMP;
            S_MUL_STEP: if (cnt_q == 5'd31) state_d = S_FIX;
            S_DIV_CMP:  state_d = S_DIV_SUB;
            S_DIV_SUB:  state_d = (cnt_q == 5'd31) ? S_FIX : S_DIV_CMP;
            S_FIX:      state_d = S_DONE;
            S_DONE:     if (resp_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // A flush abandons the operation, including a response not yet taken.
        if (kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        res_d   = res_q;
        err_d   = err_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        ge_d    = ge_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = req_op;
                    a_d   = req_a;
                    b_d   = req_b;
                    acc_d = '0;
                    quo_d = '0;
                    res_d = '0;
                    err_d = 1'b0;
                    if (req_unsup)     err_d = 1'b1;
                    else if (req_div0) res_d = req_op[1] ? req_a : '1;
                    else if (req_ovf)  res_d = req_op[1] ? '0 : req_a;
                end
            end
            S_PREP_A: begin
                a_neg_d = op_signed && a_q[W_SIZE-1];
                if (a_neg_d) a_d = alu_result;
            end
            S_PREP_B: begin
                b_neg_d = op_signed && b_q[W_SIZE-1];
                if (b_neg_d) b_d = alu_result;
                cnt_d = '0;
            end
            S_MUL_STEP: begin
                if (b_q[0]) acc_d = alu_result;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
            end
            S_DIV_CMP: begin
                // acc carries the low 32 bits of the shifted remainder into DIV_SUB
                acc_d = {acc_q[W_SIZE-2:0], a_q[W_SIZE-1]};
                a_d   = a_q << 1;
                ge_d  = acc_q[W_SIZE-1] | ~alu_result[0];
            end
            S_DIV_SUB: begin
                if (ge_q) acc_d = alu_result;
                quo_d = {quo_q[W_SIZE-2:0], ge_q};
                cnt_d = cnt_q + 5'd1;
            end
            S_FIX: begin
                err_d = 1'b0;
                if (op_q == 3'b000)
                    res_d = acc_q;
                else if (!op_q[1])
                    res_d = (op_signed && (a_neg_q ^ b_neg_q)) ? alu_result : quo_q;
                else
                    res_d = (op_signed && a_neg_q) ? alu_result : acc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_DONE);
        resp_data  = res_q;
        resp_err   = err_q;
        alu_sel    = SEL_ADD;
        alu_a      = '0;
        alu_b      = '0;
        case (state_q)
            S_PREP_A:   begin alu_sel = SEL_SUB;  alu_b = a_q; end
            S_PREP_B:   begin alu_sel = SEL_SUB;  alu_b = b_q; end
            S_MUL_STEP: begin alu_sel = SEL_ADD;  alu_a = acc_q; alu_b = a_q; end
            S_DIV_CMP:  begin alu_sel = SEL_SLTU; alu_a = {acc_q[W_SIZE-2:0], a_q[W_SIZE-1]}; alu_b = b_q; end
            S_DIV_SUB:  begin alu_sel = SEL_SUB;  alu_a = acc_q; alu_b = b_q; end
            S_FIX:      begin alu_sel = SEL_SUB;  alu_b = op_q[1] ? acc_q : quo_q; end
            default: ;
        endcase
    end

endmodule
